// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks destination registers of in-flight writes and
// blocks issue on RAW/WAW hazards or when the outstanding-write limit is reached.
module regfile_scoreboard #(
    parameter int NREGS   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_val,
    output logic                     issue_rdy,
    input  logic                     issue_rs1_en,
    input  logic [$clog2(NREGS)-1:0] issue_rs1,
    input  logic                     issue_rs2_en,
    input  logic [$clog2(NREGS)-1:0] issue_rs2,
    input  logic                     issue_rd_en,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    input  logic                     wb_val,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic                     flush,
    output logic [NREGS-1:0]         pending,
    output logic [5:0]               num_out,
    output logic                     full,
    output logic                     err
);

    localparam logic [5:0] MaxCount = 6'(MAX_OUT);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [5:0]       numOut_q, numOut_d;
    logic             err_q, err_d;

    logic raw1, raw2, waw, capBlock;
    logic issueFire, setEn, wbActive, wbHit, wbErr;

    // Hazards look only at registered state, so a same-cycle writeback never wakes a reader.
    always_comb begin
        raw1      = issue_rs1_en & pending_q[issue_rs1];
        raw2      = issue_rs2_en & pending_q[issue_rs2];
        waw       = issue_rd_en & pending_q[issue_rd];
        full      = (numOut_q == MaxCount);
        capBlock  = issue_rd_en & (issue_rd != '0) & full;
        issue_rdy = ~rst & ~flush & ~raw1 & ~raw2 & ~waw & ~capBlock;
        issueFire = issue_val & issue_rdy;
        setEn     = issueFire & issue_rd_en & (issue_rd != '0);
        wbActive  = wb_val & (wb_rd != '0) & ~flush;
        wbHit     = wbActive & pending_q[wb_rd];
        wbErr     = wbActive & ~pending_q[wb_rd];
    end

    // WAW blocking guarantees set and clear never target the same register.
    always_comb begin
        pending_d = pending_q;
        numOut_d  = numOut_q;
        err_d     = err_q | wbErr;
        if (setEn) begin
            pending_d[issue_rd] = 1'b1;
        end
        if (wbHit) begin
            pending_d[wb_rd] = 1'b0;
        end
        case ({setEn, wbHit})
            2'b10:   numOut_d = numOut_q + 6'd1;
            2'b01:   numOut_d = numOut_q - 6'd1;
            default: numOut_d = numOut_q;
        endcase
        if (flush) begin
            pending_d = '0;
            numOut_d  = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            numOut_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            numOut_q  <= numOut_d;
            err_q     <= err_d;
        end
    end

    assign pending = pending_q;
    assign num_out = numOut_q;
    assign err     = err_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry 2-read/1-write register file.
- Gates instruction issue on RAW and WAW hazards.
- Clears entries as writeback commits through the register file's write port.
- Sits between decode/issue and the multicycle execute units. Provides the single point of truth for which architectural registers hold stale data.

Parameters:
- NREGS, 32, number of architectural registers; entry 0 is hardwired zero.
- MAX_OUT, 4, maximum number of outstanding writes; range 1..31.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- issue_val  input  1  issue request valid
- issue_rdy  output  1  issue accepted this cycle (combinational)
- issue_rs1_en  input  1  instruction reads rs1
- issue_rs1  input  5  source register 1 address
- issue_rs2_en  input  1  instruction reads rs2
- issue_rs2  input  5  source register 2 address
- issue_rd_en  input  1  instruction writes rd
- issue_rd  input  5  destination register address
- wb_val  input  1  writeback committing to the register file this cycle
- wb_rd  input  5  writeback destination address
- flush  input  1  squash all outstanding writes
- pending  output  32  per-register pending bit; bit 0 always 0
- num_out  output  6  count of set pending bits
- full  output  1  num_out == MAX_OUT
- err  output  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (rst=1 at posedge): pending=0, num_out=0, err=0. Reset has priority over flush, issue and writeback. issue_rdy is 0 while rst is high.
- Hazard terms (combinational, from registered pending only):
  - raw1 = issue_rs1_en & pending[issue_rs1]
  - raw2 = issue_rs2_en & pending[issue_rs2]
  - waw = issue_rd_en & pending[issue_rd]
  - cap = issue_rd_en & (issue_rd!=0) & full
- issue_rdy = ~rst & ~flush & ~raw1 & ~raw2 & ~waw & ~cap. issue_rdy is independent of issue_val.
- Fire condition: issue_fire = issue_val & issue_rdy.
- No same-cycle wakeup. A writeback to register r does not unblock a reader of r in the same cycle, because the register file returns old data when waddr==raddr. Issue of that reader succeeds the following cycle at the earliest.
- Address 0:
  - pending[0] is constant 0.
  - Issue with rd=0 sets nothing and does not count toward cap.
  - Reads of x0 never stall.
  - wb_val with wb_rd=0 is ignored and does not set err.
- On issue_fire with issue_rd_en & rd!=0: pending[rd] <= 1.
- On wb_val with wb_rd!=0:
  - If pending[wb_rd]=1: pending[wb_rd] <= 0.
  - If pending[wb_rd]=0: no state change, err <= 1 (sticky until rst).
- Simultaneous issue-set and wb-clear on different registers: both apply in the same cycle; num_out unchanged net.
- Simultaneous issue and wb on the same register: impossible, because the WAW check blocks the issue. The wb clear applies.
- Full boundary: when num_out==MAX_OUT and a wb clears in the same cycle, an issue with rd is still blocked that cycle (cap uses the registered count). It is accepted the next cycle.
- flush=1 (rst=0): pending <= 0, num_out <= 0, issue_rdy=0. A concurrent wb is ignored and does not set err. err keeps its value.
- num_out always equals popcount(pending). It is updated by +1/-1/0 per cycle (or cleared), not recomputed. Range 0..MAX_OUT.
- Latency: a set or clear is visible on pending, num_out and full one cycle after the posedge that samples it.

Test Plan:
- Reset then idle: after rst, pending=0, num_out=0, full=0, err=0. issue_val=1 with rs1=5, rs2=6, rd=7 gives issue_rdy=1; next cycle pending=0x00000080, num_out=1.
- RAW, no same-cycle wakeup: rd=7 pending; issue rs1=7 gives issue_rdy=0. Cycle N: wb_val=1, wb_rd=7, still issue_rdy=0. Cycle N+1: pending[7]=0, issue_rdy=1.
- WAW and x0: rd=3 pending; issue rd=3 gives issue_rdy=0. Issue rd=0, rs1=0 with rd=3 pending gives issue_rdy=1, pending unchanged. wb_rd=0 leaves err=0.
- Capacity (MAX_OUT=4): issue rd=1,2,3,4 back-to-back gives full=1. Issue rd=5 is blocked; issue with rd_en=0 is accepted. Same-cycle wb rd=1 plus issue rd=5 gives rdy=0; next cycle accepted, num_out=4.
- Concurrent set/clear: pending {2}; same cycle issue rd=9 and wb rd=2 gives next pending=0x00000200, num_out=1.
- Errors, flush, reset: wb rd=12 not pending gives err=1 sticky. flush with 3 pending gives pending=0, num_out=0, err still 1. rst mid-stream gives all outputs zero next cycle.
